i2c_expander_arb: RTL

//  Round-robin arbiter sharing one I2C-expander MM access port (wr_rq/rd_rq/adr/data/action_done)

---
 rtl/i2c_expander_arb_if.sv | 34 +++
 rtl/i2c_expander_arb.sv | 119 +++++++++++
 2 files changed

// File: rtl/i2c_expander_arb_if.sv
// Bundle of requester-side and bridge-side signals for the expander access arbiter.
// slave is the arbiter's view; master is the view of the agents and bridge around it.
interface i2c_expander_arb_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_write;
    logic [4*N_REQ-1:0]  req_adr;
    logic [32*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]    req_grant;
    logic [N_REQ-1:0]    resp_done;
    logic                resp_err;
    logic [31:0]         resp_rdata;
    logic                busy;
    logic                wr_rq;
    logic                rd_rq;
    logic [3:0]          wr_adr;
    logic [3:0]          rd_adr;
    logic [31:0]         wr_data;
    logic [31:0]         rd_data;
    logic                action_done;

    modport slave (
        input  req_valid, req_write, req_adr, req_wdata, rd_data, action_done,
        output req_grant, resp_done, resp_err, resp_rdata, busy,
               wr_rq, rd_rq, wr_adr, rd_adr, wr_data
    );

    modport master (
        output req_valid, req_write, req_adr, req_wdata, rd_data, action_done,
        input  req_grant, resp_done, resp_err, resp_rdata, busy,
               wr_rq, rd_rq, wr_adr, rd_adr, wr_data
    );
endinterface

// File: rtl/i2c_expander_arb.sv
// Round-robin arbiter sharing one expander MM access port between N_REQ requesters,
// one transaction at a time, with a per-transaction timeout.
module i2c_expander_arb #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    i2c_expander_arb_if.slave    bus
);
    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [CW-1:0]   cnt;
    logic            lat_write;

    logic            found;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   ptr_nxt;
    logic [PW:0]     sum;
    logic [PW-1:0]   cand;

    logic [3:0]      adr_a [N_REQ];
    logic [31:0]     wd_a  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign adr_a[g] = bus.req_adr[4*g +: 4];
        assign wd_a[g]  = bus.req_wdata[32*g +: 32];
    end

    // Rotating priority search starting at ptr; wraps without a modulo operator.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(N_REQ))
                sum = sum - (PW+1)'(N_REQ);
            cand = sum[PW-1:0];
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        ptr_nxt = (pick == PW'(N_REQ-1)) ? '0 : pick + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= '0;
            win            <= '0;
            cnt            <= '0;
            lat_write      <= 1'b0;
            bus.req_grant  <= '0;
            bus.resp_done  <= '0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.busy       <= 1'b0;
            bus.wr_rq      <= 1'b0;
            bus.rd_rq      <= 1'b0;
            bus.wr_adr     <= '0;
            bus.rd_adr     <= '0;
            bus.wr_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_grant <= '0;
                    bus.resp_done <= '0;
                    cnt           <= '0;
                    if (found) begin
                        win           <= pick;
                        lat_write     <= bus.req_write[pick];
                        bus.req_grant <= N_REQ'(1) << pick;
                        bus.wr_rq     <= bus.req_write[pick];
                        bus.rd_rq     <= !bus.req_write[pick];
                        bus.wr_adr    <= bus.req_write[pick] ? adr_a[pick] : '0;
                        bus.rd_adr    <= bus.req_write[pick] ? '0 : adr_a[pick];
                        bus.wr_data   <= wd_a[pick];
                        bus.busy      <= 1'b1;
                        ptr           <= ptr_nxt;
                        state         <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    bus.req_grant <= '0;
                    // action_done is tested first so it wins over a coincident timeout.
                    if (bus.action_done || cnt == CW'(TIMEOUT_CYC-1)) begin
                        bus.resp_err   <= !bus.action_done;
                        bus.resp_rdata <= (bus.action_done && !lat_write) ? bus.rd_data : '0;
                        bus.resp_done  <= N_REQ'(1) << win;
                        bus.wr_rq      <= 1'b0;
                        bus.rd_rq      <= 1'b0;
                        bus.wr_adr     <= '0;
                        bus.rd_adr     <= '0;
                        bus.wr_data    <= '0;
                        state          <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    bus.resp_done <= '0;
                    bus.busy      <= 1'b0;
                    cnt           <= '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
